// File: rtl/gpu_pkg.sv
// Shared FMA/memory constants and types; the memory block imports the same
// line width and slot layout.
package gpu_pkg;

  localparam int unsigned FMA_COUNT   = 2;
  localparam int unsigned WORD_WIDTH  = 16;
  localparam int unsigned SLOTS       = 3;
  localparam int unsigned SET_WIDTH   = FMA_COUNT * WORD_WIDTH;
  localparam int unsigned LINE_WIDTH  = SLOTS * SET_WIDTH;
  localparam int unsigned COUNT_WIDTH = $clog2(SLOTS + 1);
  localparam int unsigned DROP_WIDTH  = 8;

  typedef logic [WORD_WIDTH-1:0] word_t;
  // One lockstep result set: FMA i occupies word i.
  typedef word_t [FMA_COUNT-1:0] set_t;
  // One cache line: slot k holds set k, slot 0 in the low bits.
  typedef set_t [SLOTS-1:0] line_t;

  typedef enum logic {WB_FILL, WB_FULL} wb_state_t;

endpackage

// File: rtl/fma_write_buffer.sv
// Packs consecutive FMA result sets into one cache line and holds it with a
// level valid until the controller acknowledges the memory has taken it.
// Optional feature macro: FMA_WB_DROP_COUNT_EN adds an 8-bit saturating
// dropped-result counter output (drop_count_out).
module fma_write_buffer
  import gpu_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [SET_WIDTH-1:0]   fma_c_in,
  input  logic                   fma_valid_in,
  input  logic                   flush_in,
  input  logic                   buffer_read_in,
  output logic [LINE_WIDTH-1:0]  line_out,
  output logic                   line_valid_out,
  output logic [COUNT_WIDTH-1:0] fill_count_out,
  output logic                   overflow_out
`ifdef FMA_WB_DROP_COUNT_EN
  ,
  output logic [DROP_WIDTH-1:0]  drop_count_out
`endif
);

  wb_state_t              state_q;
  line_t                  line_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   line_valid_q;
  logic                   overflow_q;

  line_t                  line_cap_c;
  logic [COUNT_WIDTH-1:0] count_cap_c;
  logic                   publish_c;
  line_t                  line_restart_c;
  logic                   drop_c;

  // Capture datapath: the line/count after this cycle's result is written,
  // plus the cleared line seeded with a result arriving alongside an ack.
  always_comb begin
    line_cap_c  = line_q;
    count_cap_c = count_q;
    if (fma_valid_in && (count_q < COUNT_WIDTH'(SLOTS))) begin
      line_cap_c[count_q] = set_t'(fma_c_in);
      count_cap_c         = count_q + COUNT_WIDTH'(1);
    end
    // Flush sees the post-capture count so a same-cycle result is included.
    publish_c = (count_cap_c == COUNT_WIDTH'(SLOTS)) ||
                (flush_in && (count_cap_c != '0));
    line_restart_c = '0;
    if (fma_valid_in) begin
      line_restart_c[0] = set_t'(fma_c_in);
    end
    drop_c = (state_q == WB_FULL) && fma_valid_in && !buffer_read_in;
  end

  // Fill/full state machine with registered line, count, valid and overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= WB_FILL;
      line_q       <= '0;
      count_q      <= '0;
      line_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        WB_FILL: begin
          line_q  <= line_cap_c;
          count_q <= count_cap_c;
          if (publish_c) begin
            state_q      <= WB_FULL;
            line_valid_q <= 1'b1;
          end
        end
        WB_FULL: begin
          if (buffer_read_in) begin
            line_q       <= line_restart_c;
            count_q      <= fma_valid_in ? COUNT_WIDTH'(1) : COUNT_WIDTH'(0);
            line_valid_q <= 1'b0;
            state_q      <= WB_FILL;
          end else if (drop_c) begin
            overflow_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WB_FILL;
        end
      endcase
    end
  end

`ifdef FMA_WB_DROP_COUNT_EN
  logic [DROP_WIDTH-1:0] drop_count_q;

  // Saturating count of results dropped while the line waits for its ack.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      drop_count_q <= '0;
    end else if (drop_c && (drop_count_q != {DROP_WIDTH{1'b1}})) begin
      drop_count_q <= drop_count_q + DROP_WIDTH'(1);
    end
  end

  assign drop_count_out = drop_count_q;
`endif

  assign line_out       = LINE_WIDTH'(line_q);
  assign line_valid_out = line_valid_q;
  assign fill_count_out = count_q;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_fma_write_buffer.sv
// Scoreboard bench for fma_write_buffer: directed scenarios plus random
// traffic, checked against a queue-of-result-sets reference model.
module tb_fma_write_buffer;
  import gpu_pkg::*;

  typedef struct packed {
    logic [LINE_WIDTH-1:0]  line;
    logic                   valid;
    logic [COUNT_WIDTH-1:0] count;
    logic                   ovf;
    logic [7:0]             drops;
  } exp_t;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b0;
  logic [SET_WIDTH-1:0]   fma_c_in = '0;
  logic                   fma_valid_in = 1'b0;
  logic                   flush_in = 1'b0;
  logic                   buffer_read_in = 1'b0;
  logic [LINE_WIDTH-1:0]  line_out;
  logic                   line_valid_out;
  logic [COUNT_WIDTH-1:0] fill_count_out;
  logic                   overflow_out;
`ifdef FMA_WB_DROP_COUNT_EN
  logic [7:0]             drop_count_out;
`endif

  fma_write_buffer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .fma_c_in       (fma_c_in),
    .fma_valid_in   (fma_valid_in),
    .flush_in       (flush_in),
    .buffer_read_in (buffer_read_in),
    .line_out       (line_out),
    .line_valid_out (line_valid_out),
    .fill_count_out (fill_count_out),
    .overflow_out   (overflow_out)
`ifdef FMA_WB_DROP_COUNT_EN
    ,
    .drop_count_out (drop_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // Reference model: the captured sets in arrival order, a published flag,
  // sticky overflow and a saturating drop count.
  logic [SET_WIDTH-1:0] m_sets[$];
  bit                   m_full = 1'b0;
  bit                   m_ovf = 1'b0;
  int                   m_drops = 0;
  exp_t                 exp_q[$];

  task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act,
                     input logic [LINE_WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e       = '0;
    for (int k = 0; k < m_sets.size(); k++) e.line[k*SET_WIDTH +: SET_WIDTH] = m_sets[k];
    e.valid = m_full;
    e.count = COUNT_WIDTH'(m_sets.size());
    e.ovf   = m_ovf;
    e.drops = 8'(m_drops);
    return e;
  endfunction

  function automatic void model_step(input logic rst, input logic v, input logic f,
                                     input logic r, input logic [SET_WIDTH-1:0] d);
    if (rst) begin
      m_sets.delete();
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (!m_full) begin
      if (v) m_sets.push_back(d);
      if (m_sets.size() == SLOTS || (f && m_sets.size() > 0)) m_full = 1'b1;
    end else if (r) begin
      m_sets.delete();
      m_full = 1'b0;
      if (v) m_sets.push_back(d);
    end else if (v) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
  endfunction

  // One clock: drive at negedge, advance the model at posedge, queue expectation.
  task automatic step(input logic rst, input logic v, input logic f, input logic r,
                      input logic [SET_WIDTH-1:0] d);
    @(negedge clk_in);
    rst_in         = rst;
    fma_valid_in   = v;
    flush_in       = f;
    buffer_read_in = r;
    fma_c_in       = d;
    @(posedge clk_in);
    model_step(rst, v, f, r, d);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare every registered output just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("line_out", line_out, e.line);
        chk("line_valid_out", LINE_WIDTH'(line_valid_out), LINE_WIDTH'(e.valid));
        chk("fill_count_out", LINE_WIDTH'(fill_count_out), LINE_WIDTH'(e.count));
        chk("overflow_out", LINE_WIDTH'(overflow_out), LINE_WIDTH'(e.ovf));
`ifdef FMA_WB_DROP_COUNT_EN
        chk("drop_count_out", LINE_WIDTH'(drop_count_out), LINE_WIDTH'(e.drops));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_WIDTH-1:0] case1_line;
    case1_line = 96'h0C00_0300_0800_0200_0400_0100;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Full line
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0400_0100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0800_0200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0C00_0300);
    #2;
    chk("case1_literal_line", line_out, case1_line);
    chk("case1_literal_valid", LINE_WIDTH'(line_valid_out), LINE_WIDTH'(1));

    // Hold for 10 cycles, then ack
    idle(10);
    #2;
    chk("case2_held_line", line_out, case1_line);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(1);

    // Ack coinciding with a new result
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0002);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0003_0004);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0005_0006);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_2222);
    #2;
    chk("case3_slot0", line_out, 96'h0000_0000_0000_0000_1111_2222);

    // Overflow: fill up, drop results, sticky after ack
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h3333_4444);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h5555_6666);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
`ifdef FMA_WB_DROP_COUNT_EN
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'($urandom));
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(2);

    // Flush a partial line; flush on an empty line is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA_5555);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    #2;
    chk("case5_flush_line", line_out, 96'h0000_0000_0000_0000_AAAA_5555);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    // Flush with a coincident capture on an empty line, and on one slot
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0FED_CBA9);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Reset mid-fill, then a clean full line
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h7777_8888);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h9999_AAAA);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0400_0100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0800_0200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0C00_0300);
    #2;
    chk("case6_refill_line", line_out, case1_line);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3), 32'($urandom));
    end

    idle(3);
    #2;
    chk("scoreboard_drained", LINE_WIDTH'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fma_write_buffer.md
Name: fma_write_buffer

Overview:
Collects result words from the FMA array and packs them into one data-cache line for the memory block. Sits between the FMA outputs and the memory's write-buffer input port. Holds up to SLOTS consecutive FMA result sets, then presents the packed line with a level valid. Holds that valid until the controller acknowledges the memory's consumption of the line (LOADB issue).

Parameters:
FMA_COUNT, 2, number of FMAs producing results in lockstep
WORD_WIDTH, 16, bits per fixed-point word
SLOTS, 3, result sets per line
LINE_WIDTH, SLOTS*FMA_COUNT*WORD_WIDTH (96), packed line width; must equal the memory line width

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
fma_c_in  input  FMA_COUNT*WORD_WIDTH  FMA results; FMA i at [i*WORD_WIDTH +: WORD_WIDTH]
fma_valid_in  input  1  all FMAs present valid results this cycle
flush_in  input  1  publish a partially filled line
buffer_read_in  input  1  controller ack: memory has taken the line
line_out  output  LINE_WIDTH  packed line; slot k, FMA i at [k*FMA_COUNT*WORD_WIDTH + i*WORD_WIDTH +: WORD_WIDTH]
line_valid_out  output  1  line_out is complete and stable
fill_count_out  output  $clog2(SLOTS+1)  number of captured slots
overflow_out  output  1  sticky: a result was dropped while FULL

Behaviour:
- Clocking and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: line_out=0, line_valid_out=0, fill_count_out=0, overflow_out=0, state=FILL. A reset mid-operation discards all captured data.
- State FILL:
  - When fma_valid_in is high, fma_c_in is written to slot fill_count_out and the count increments.
  - When the count reaches SLOTS, the state moves to FULL. line_valid_out goes high on the cycle after the third capture.
- Flush in FILL:
  - flush_in with count>0 moves the state to FULL next cycle. Unfilled slots read as 0.
  - If flush_in and fma_valid_in arrive together, the capture happens first and the flushed line includes the new slot.
  - flush_in with count==0 and no valid is ignored.
- State FULL:
  - line_valid_out=1 and line_out is held stable.
  - On buffer_read_in: next cycle line_out=0, count=0, line_valid_out=0, state=FILL.
  - If buffer_read_in and fma_valid_in arrive together, the new result goes to slot 0 of the cleared line: count=1, state=FILL.
  - fma_valid_in without buffer_read_in drops the result and sets overflow_out=1. overflow_out stays set until reset.
  - flush_in is ignored in FULL.
- buffer_read_in is ignored in FILL.
- Valid is level, not a pulse. The memory may sample line_out on any cycle while line_valid_out=1.
- No arithmetic is performed on data words; they are copied bit-exact. fill_count_out never exceeds SLOTS.
- Throughput: one result set per cycle in FILL. The only bubble is the ack cycle, which is avoided when ack and valid coincide.

Optional Feature:
- Macro: FMA_WB_DROP_COUNT_EN.
- With the macro defined: adds output drop_count_out (8 bits, reset 0). It increments on every dropped result and saturates at 255.
- Without the macro: the port and counter are absent, and only the sticky overflow_out reports drops.

Decomposition:
- Shared package gpu_pkg holds:
  - constants FMA_COUNT, WORD_WIDTH, SLOTS, LINE_WIDTH;
  - typedef word_t (logic[WORD_WIDTH-1:0]);
  - typedef line_t;
  - enum wb_state_t {WB_FILL, WB_FULL}.
- The memory block imports the same LINE_WIDTH and slot-layout constants.
- Single module; no sub-module is needed.

Test Plan:
1. Full line: reset; then 3 valid cycles with fma_c_in={0x0400,0x0100}, {0x0800,0x0200}, {0x0C00,0x0300} -> next cycle line_valid_out=1, line_out=0x0C00_0300_0800_0200_0400_0100, fill_count_out=3.
2. Hold and ack: from case 1, hold buffer_read_in=0 for 10 cycles -> line_out is unchanged. Then pulse buffer_read_in -> next cycle line_valid_out=0, line_out=0, count=0.
3. Ack with new valid: in FULL, buffer_read_in=1 with fma_valid_in=1 and {0x1111,0x2222} -> line_out low slot=0x1111_2222, count=1, valid=0.
4. Overflow: in FULL, fma_valid_in=1 without ack -> line_out is unchanged and overflow_out=1, and it stays 1 after the later ack. With FMA_WB_DROP_COUNT_EN, 300 drops -> drop_count_out=255.
5. Flush: capture one slot {0xAAAA,0x5555}, then flush_in=1 -> line_valid_out=1, line_out=0x0000_0000_0000_0000_AAAA_5555. flush_in with count=0 -> no change.
6. Reset mid-fill: two captures, then rst_in=1 for one cycle -> all outputs 0. A following 3-capture fill then behaves exactly as in case 1.
